// File: rtl/bitwise_unit_seq.sv
// rtl/bitwise_unit_seq.sv - chunk-serial bitwise logic unit, one CHUNK-bit slice per clock
// Operands and op are captured at start; res/zero/ones update only when the last slice lands.
module bitwise_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ones,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q, ones_q, busy_q, done_q;

  logic [CHUNK-1:0] sa, sb, slice_d;
  logic [WIDTH-1:0] acc_d;
  logic             last_slice;
  int               base;

  always_comb begin
    base       = int'(cnt_q) * CHUNK;
    sa         = a_q[base +: CHUNK];
    sb         = b_q[base +: CHUNK];
    case (op_q)
      3'b000:  slice_d = sa & sb;
      3'b001:  slice_d = sa | sb;
      3'b010:  slice_d = sa ^ sb;
      3'b011:  slice_d = ~(sa | sb);
      3'b100:  slice_d = ~(sa & sb);
      3'b101:  slice_d = ~(sa ^ sb);
      3'b110:  slice_d = sa & ~sb;
      default: slice_d = sa;
    endcase
    // acc_d already holds the complete word on the last slice, so res loads from it directly
    acc_d             = acc_q;
    acc_d[base +: CHUNK] = slice_d;
    last_slice        = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ones_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_slice) begin
            res_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            ones_q  <= &acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res  = res_q;
  assign zero = zero_q;
  assign ones = ones_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
